// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle divider and its execute-stage decode.
package div_unit_pkg;

    // Divider control states (2-bit encoding)
    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    // ALU operation codes that route to the divider
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    // True when the decoded ALU op needs the divider (used by ex to raise div_start)
    function automatic logic is_div_op(input logic [7:0] aluop);
        return (aluop == EXE_DIV_OP) || (aluop == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/div_unit.sv
// Restoring integer divider, one quotient bit per clock, with start/ready
// handshake and annul for flushed operations. Result is {remainder, quotient}.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 div_zero_o
);

    // Two's complement negate when en is set; shared by operand and result paths
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic en);
        return en ? (~v + WIDTH'(1)) : v;
    endfunction

    div_state_e state_q, state_d;

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH:0]   work_q, work_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic               q_sign_q, q_sign_d;
    logic               r_sign_q, r_sign_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               div_zero_q, div_zero_d;

    logic               take;
    logic               op1_neg, op2_neg;
    logic [WIDTH-1:0]   op1_mag, op2_mag;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH:0]   step_work;
    logic               last_step;

    // Operand conditioning at start: magnitudes only for negative signed operands
    always_comb begin
        take    = (start_i == DivStart) && !annul_i;
        op1_neg = signed_div_i & opdata1_i[WIDTH-1];
        op2_neg = signed_div_i & opdata2_i[WIDTH-1];
        op1_mag = cond_neg(opdata1_i, op1_neg);
        op2_mag = cond_neg(opdata2_i, op2_neg);
    end

    // One restoring step; trial sign bit decides subtract-or-shift
    always_comb begin
        trial     = work_q[2*WIDTH:WIDTH] - {1'b0, divisor_q};
        step_work = trial[WIDTH] ? {work_q[2*WIDTH-1:0], 1'b0}
                                 : {trial[WIDTH-1:0], work_q[WIDTH-1:0], 1'b1};
        last_step = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DivFree;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; annul wins over start everywhere
    always_comb begin
        state_d = state_q;
        case (state_q)
            DivFree: begin
                if (take) begin
                    state_d = (opdata2_i == '0) ? DivByZero : DivOn;
                end
            end
            DivByZero: begin
                state_d = annul_i ? DivFree : DivEnd;
            end
            DivOn: begin
                if (annul_i) begin
                    state_d = DivFree;
                end else if (last_step) begin
                    state_d = DivEnd;
                end
            end
            DivEnd: begin
                if (annul_i || (start_i == DivStop)) begin
                    state_d = DivFree;
                end
            end
            default: state_d = DivFree;
        endcase
    end

    // Outputs: ready is a pure function of state, result/flag are registered
    always_comb begin
        ready_o    = (state_q == DivEnd) ? DivResultReady : DivResultNotReady;
        result_o   = result_q;
        div_zero_o = div_zero_q;
    end

    // Datapath next-state: latch operands, iterate, sign-correct on the final step
    always_comb begin
        cnt_d      = cnt_q;
        work_d     = work_q;
        divisor_d  = divisor_q;
        q_sign_d   = q_sign_q;
        r_sign_d   = r_sign_q;
        result_d   = result_q;
        div_zero_d = div_zero_q;
        case (state_q)
            DivFree: begin
                result_d   = '0;
                div_zero_d = 1'b0;
                cnt_d      = '0;
                if (take) begin
                    divisor_d = op2_mag;
                    q_sign_d  = op1_neg ^ op2_neg;
                    r_sign_d  = op1_neg;
                    work_d    = {{WIDTH{1'b0}}, op1_mag, 1'b0};
                end
            end
            DivByZero: begin
                if (annul_i) begin
                    cnt_d = '0;
                end else begin
                    result_d   = '0;
                    div_zero_d = 1'b1;
                end
            end
            DivOn: begin
                if (annul_i) begin
                    cnt_d = '0;
                end else begin
                    work_d = step_work;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (last_step) begin
                        result_d   = {cond_neg(step_work[2*WIDTH:WIDTH+1], r_sign_q),
                                      cond_neg(step_work[WIDTH-1:0], q_sign_q)};
                        div_zero_d = 1'b0;
                    end
                end
            end
            DivEnd: begin
                if (annul_i || (start_i == DivStop)) begin
                    result_d   = '0;
                    div_zero_d = 1'b0;
                    cnt_d      = '0;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            work_q     <= '0;
            divisor_q  <= '0;
            q_sign_q   <= 1'b0;
            r_sign_q   <= 1'b0;
            result_q   <= '0;
            div_zero_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            divisor_q  <= divisor_d;
            q_sign_q   <= q_sign_d;
            r_sign_q   <= r_sign_d;
            result_q   <= result_d;
            div_zero_q <= div_zero_d;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: 32-bit and 8-bit instances, arithmetic model
// plus hand-computed literals, per-cycle ready/result comparison.
module tb_div_unit;

    logic        clk;
    logic        rst;

    logic        s32, start32, annul32;
    logic [31:0] a32, b32;
    logic [63:0] res32;
    logic        rdy32, dz32;

    logic        s8, start8, annul8;
    logic [7:0]  a8, b8;
    logic [15:0] res8;
    logic        rdy8, dz8;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model-side expectations published by the drivers
    bit          busy32 = 0, busy8 = 0, expdz32 = 0, expdz8 = 0;
    int          lat32 = 0, lat8 = 0, start_cyc32 = 0, start_cyc8 = 0;
    logic [63:0] exp32 = '0;
    logic [15:0] exp8 = '0;

    div_unit #(.WIDTH(32), .CNT_W(7)) u_div32 (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (s32),
        .opdata1_i    (a32),
        .opdata2_i    (b32),
        .start_i      (start32),
        .annul_i      (annul32),
        .result_o     (res32),
        .ready_o      (rdy32),
        .div_zero_o   (dz32)
    );

    div_unit #(.WIDTH(8), .CNT_W(4)) u_div8 (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (s8),
        .opdata1_i    (a8),
        .opdata2_i    (b8),
        .start_i      (start8),
        .annul_i      (annul8),
        .result_o     (res8),
        .ready_o      (rdy8),
        .div_zero_o   (dz8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Plain-arithmetic reference: truncating division, remainder follows dividend
    function automatic logic [127:0] model_div(input int w, input bit sgn,
                                               input logic [63:0] a, input logic [63:0] b);
        logic [63:0] mask;
        longint sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        mask = (64'd1 << w) - 64'd1;
        ua = a & mask;
        ub = b & mask;
        if (ub == 0) return '0;
        if (sgn) begin
            sa = $signed(ua << (64 - w)) >>> (64 - w);
            sb = $signed(ub << (64 - w)) >>> (64 - w);
            sq = sa / sb;
            sr = sa % sb;
            uq = sq;
            ur = sr;
        end else begin
            uq = ua / ub;
            ur = ua % ub;
        end
        return ({64'b0, ur & mask} << w) | {64'b0, uq & mask};
    endfunction

    // Per-cycle compare: ready exactly from the expected latency on, result when ready
    always @(negedge clk) begin
        if (busy32 && (cyc - start_cyc32) >= lat32) begin
            chk("cmp_rdy32", {127'b0, rdy32}, 128'd1);
            chk("cmp_res32", {64'b0, res32}, {64'b0, exp32});
            chk("cmp_dz32", {127'b0, dz32}, {127'b0, expdz32});
        end else begin
            chk("cmp_rdy32_low", {127'b0, rdy32}, 128'd0);
        end
        if (busy8 && (cyc - start_cyc8) >= lat8) begin
            chk("cmp_rdy8", {127'b0, rdy8}, 128'd1);
            chk("cmp_res8", {112'b0, res8}, {112'b0, exp8});
            chk("cmp_dz8", {127'b0, dz8}, {127'b0, expdz8});
        end else begin
            chk("cmp_rdy8_low", {127'b0, rdy8}, 128'd0);
        end
    end

    task automatic wait_ready32(input int budget, output bit ok);
        int n;
        ok = 0;
        n = 0;
        while (!ok && n < budget) begin
            @(negedge clk);
            if (rdy32) ok = 1;
            n++;
        end
    endtask

    task automatic wait_ready8(input int budget, output bit ok);
        int n;
        ok = 0;
        n = 0;
        while (!ok && n < budget) begin
            @(negedge clk);
            if (rdy8) ok = 1;
            n++;
        end
    endtask

    // Start a 32-bit op and hold start; returns with inputs applied before the sampling edge
    task automatic launch32(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        logic [127:0] m;
        m = model_div(32, sgn, {32'b0, a}, {32'b0, b});
        @(posedge clk); #1;
        exp32       = m[63:0];
        expdz32     = (b == 32'd0);
        lat32       = (b == 32'd0) ? 2 : 33;
        s32         = sgn;
        a32         = a;
        b32         = b;
        start32     = 1'b1;
        start_cyc32 = cyc;
        busy32      = 1'b1;
    endtask

    // Full handshake: start, wait, check literal, drop start, check return to idle
    task automatic op32(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] lit, input string name);
        bit ok;
        chk({name, "_model"}, model_div(32, sgn, {32'b0, a}, {32'b0, b}), {64'b0, lit});
        launch32(sgn, a, b);
        wait_ready32(lat32 + 4, ok);
        chk({name, "_done"}, {127'b0, ok}, 128'd1);
        chk({name, "_res"}, {64'b0, res32}, {64'b0, lit});
        chk({name, "_dz"}, {127'b0, dz32}, {127'b0, (b == 32'd0)});
        @(posedge clk); #1 start32 = 1'b0;
        @(posedge clk); #1 busy32 = 1'b0;
        chk({name, "_idle_rdy"}, {127'b0, rdy32}, 128'd0);
        chk({name, "_idle_res"}, {64'b0, res32}, 128'd0);
        chk({name, "_idle_dz"}, {127'b0, dz32}, 128'd0);
    endtask

    task automatic op8(input bit sgn, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] lit, input string name);
        bit ok;
        logic [127:0] m;
        m = model_div(8, sgn, {56'b0, a}, {56'b0, b});
        chk({name, "_model"}, m, {112'b0, lit});
        @(posedge clk); #1;
        exp8       = m[15:0];
        expdz8     = (b == 8'd0);
        lat8       = (b == 8'd0) ? 2 : 9;
        s8         = sgn;
        a8         = a;
        b8         = b;
        start8     = 1'b1;
        start_cyc8 = cyc;
        busy8      = 1'b1;
        wait_ready8(lat8 + 4, ok);
        chk({name, "_done"}, {127'b0, ok}, 128'd1);
        chk({name, "_res"}, {112'b0, res8}, {112'b0, lit});
        @(posedge clk); #1 start8 = 1'b0;
        @(posedge clk); #1 busy8 = 1'b0;
        chk({name, "_idle_rdy"}, {127'b0, rdy8}, 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst = 1'b0;
        s32 = 0; start32 = 0; annul32 = 0; a32 = '0; b32 = '0;
        s8 = 0; start8 = 0; annul8 = 0; a8 = '0; b8 = '0;
        #2;
        chk("reset_rdy", {127'b0, rdy32}, 128'd0);
        chk("reset_res", {64'b0, res32}, 128'd0);
        chk("reset_dz", {127'b0, dz32}, 128'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        op32(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, "u100_7");
        op32(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "s_m7_2");
        op32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, "s_ovf");
        op32(1'b0, 32'd5, 32'd0, 64'h0, "u5_0");
        op32(1'b1, 32'd100, 32'hFFFF_FFF9, {32'd2, 32'hFFFF_FFF2}, "s100_m7");
        op32(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'd14}, "s_m100_m7");
        op32(1'b0, 32'hFFFF_FFF9, 32'd2, {32'd1, 32'h7FFF_FFFC}, "u_big_2");

        // Annul ten edges into ON: no result, then a clean 9/3
        launch32(1'b0, 32'd1000, 32'd7);
        lat32 = 100000;
        repeat (11) @(posedge clk);
        #1 annul32 = 1'b1;
        @(posedge clk);
        #1 annul32 = 1'b0; start32 = 1'b0; busy32 = 1'b0;
        repeat (40) @(posedge clk);
        #1 chk("annul_on_rdy", {127'b0, rdy32}, 128'd0);
        op32(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, "u9_3_after_annul");

        // Annul while in BYZERO
        launch32(1'b0, 32'd5, 32'd0);
        lat32 = 100000;
        @(posedge clk);
        #1 annul32 = 1'b1;
        @(posedge clk);
        #1 annul32 = 1'b0; start32 = 1'b0; busy32 = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("annul_bz_dz", {127'b0, dz32}, 128'd0);

        // Annul in END with start still high: annul wins, back to idle
        launch32(1'b0, 32'd9, 32'd4);
        wait_ready32(40, ok);
        chk("annul_end_done", {127'b0, ok}, 128'd1);
        chk("annul_end_res", {64'b0, res32}, {32'd1, 32'd2});
        @(posedge clk); #1 annul32 = 1'b1;
        @(posedge clk);
        #1 annul32 = 1'b0; start32 = 1'b0; busy32 = 1'b0;
        chk("annul_end_rdy", {127'b0, rdy32}, 128'd0);
        chk("annul_end_idle_res", {64'b0, res32}, 128'd0);
        repeat (3) @(posedge clk);

        // Start dropped mid-ON and operands scrambled: op still completes once
        launch32(1'b0, 32'd1003, 32'd10);
        repeat (5) @(posedge clk);
        #1 start32 = 1'b0; a32 = 32'hDEAD_BEEF; b32 = 32'h0;
        wait_ready32(40, ok);
        chk("drop_done", {127'b0, ok}, 128'd1);
        chk("drop_res", {64'b0, res32}, {32'd3, 32'd100});
        @(posedge clk); #1 busy32 = 1'b0;
        chk("drop_exit_rdy", {127'b0, rdy32}, 128'd0);

        op8(1'b0, 8'd200, 8'd3, {8'd2, 8'd66}, "w8_u200_3");
        op8(1'b1, 8'h9C, 8'd7, {8'hFE, 8'hF2}, "w8_s_m100_7");

        // Asynchronous reset while in END: outputs clear with no clock edge
        launch32(1'b0, 32'd100, 32'd7);
        wait_ready32(40, ok);
        chk("rst_end_done", {127'b0, ok}, 128'd1);
        #2 rst = 1'b0; busy32 = 1'b0; start32 = 1'b0;
        #1;
        chk("rst_end_rdy", {127'b0, rdy32}, 128'd0);
        chk("rst_end_res", {64'b0, res32}, 128'd0);
        @(posedge clk); #1 rst = 1'b1;

        // Asynchronous reset mid-ON, then restart
        launch32(1'b0, 32'd77, 32'd5);
        repeat (10) @(posedge clk);
        #3 rst = 1'b0; busy32 = 1'b0; start32 = 1'b0;
        #1;
        chk("rst_on_rdy", {127'b0, rdy32}, 128'd0);
        chk("rst_on_res", {64'b0, res32}, 128'd0);
        chk("rst_on_dz", {127'b0, dz32}, 128'd0);
        @(posedge clk); #1 rst = 1'b1;
        op32(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, "u9_3_after_rst");

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
